// File: rtl/tt_sweep.sv
// tt_sweep: drives a 4-input combinational block through all 16 input vectors,
// captures its output f into a truth table and compares it with an expected table.
// Latency: 16*DWELL cycles from the edge that samples start to done; no backpressure.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              begin a sweep (level-sampled, honoured only in IDLE/DONE)
//   expected[15:0]     expected truth table, latched when a sweep starts
//   f                  output of the block under test
//   a, b, c, d         stimulus, {a,b,c,d} = current vector index
//   busy, done         sweep in progress / sweep complete (held until restart)
//   truth_table[15:0]  captured table, bit i = f sampled for vector i
//   mismatch_count     number of differing bits (0..16)
//   first_fail         lowest failing vector index, 0 if none
//   pass               done and no mismatches
module tt_sweep #(
    parameter int unsigned DWELL = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  cnt;
    logic [15:0] exp_q;
    logic        sample;
    logic        miss;
    logic        launch;

    // f is taken on the last cycle of each dwell window.
    assign sample = (state == RUN) && (cnt == CNT_LAST);
    assign miss   = f ^ exp_q[idx];
    assign launch = ((state == IDLE) || (state == DONE)) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (sample && (idx == 4'd15)) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= 4'd0;
            cnt            <= 8'd0;
            exp_q          <= 16'd0;
            truth_table    <= 16'd0;
            mismatch_count <= 5'd0;
            first_fail     <= 4'd0;
        end else if (launch) begin
            // Restart from DONE clears the previous result on the same edge.
            idx            <= 4'd0;
            cnt            <= 8'd0;
            exp_q          <= expected;
            truth_table    <= 16'd0;
            mismatch_count <= 5'd0;
            first_fail     <= 4'd0;
        end else if (state == RUN) begin
            if (sample) begin
                truth_table[idx] <= f;
                if (miss) begin
                    mismatch_count <= mismatch_count + 5'd1;
                    if (mismatch_count == 5'd0) begin
                        first_fail <= idx;
                    end
                end
                cnt <= 8'd0;
                // idx 15 wraps to 0, which is exactly the idle stimulus in DONE.
                idx <= idx + 4'd1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign {a, b, c, d} = idx;
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign pass         = done && (mismatch_count == 5'd0);

endmodule

// File: tb/tb_tt_sweep.sv
module tb_tt_sweep;

    typedef struct {
        logic [15:0] tbl;
        int          mm;
        int          ff;
        int          pass;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DWELL = 10 instance, block under test f = a & b
    logic        start10 = 1'b0;
    logic [15:0] expected10 = 16'h0;
    logic        f10, a10, b10, c10, d10, busy10, done10, pass10;
    logic [15:0] table10;
    logic [4:0]  mm10;
    logic [3:0]  ff10;

    // DWELL = 1 instance, block under test f = a ^ b ^ c ^ d
    logic        start1 = 1'b0;
    logic [15:0] expected1 = 16'h0;
    logic        f1, a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] table1;
    logic [4:0]  mm1;
    logic [3:0]  ff1;

    assign f10 = a10 & b10;
    assign f1  = a1 ^ b1 ^ c1 ^ d1;

    tt_sweep #(.DWELL(10)) u10 (
        .clk(clk), .rst(rst), .start(start10), .expected(expected10), .f(f10),
        .a(a10), .b(b10), .c(c10), .d(d10), .busy(busy10), .done(done10),
        .truth_table(table10), .mismatch_count(mm10), .first_fail(ff10), .pass(pass10)
    );

    tt_sweep #(.DWELL(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1), .f(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .truth_table(table1), .mismatch_count(mm1), .first_fail(ff1), .pass(pass1)
    );

    exp_t q10[$];
    exp_t q1[$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    logic done10_prev = 1'b0, busy10_prev = 1'b0;
    int   rs10 = 0;
    exp_t e10;
    always @(negedge clk) begin
        if (done10 && !done10_prev) begin
            if (q10.size() == 0) begin
                chk("unexpected_done10", 1, 0);
            end else begin
                e10 = q10.pop_front();
                chk("table10", table10, e10.tbl);
                chk("mismatch10", mm10, e10.mm);
                chk("first_fail10", ff10, e10.ff);
                chk("pass10", pass10, e10.pass);
                chk("done_cycle10", cyc, e10.cyc);
                chk("busy_at_done10", busy10, 0);
            end
        end
        if (busy10) begin
            if (!busy10_prev) rs10 = cyc;
            chk("vector10", {a10, b10, c10, d10}, (cyc - rs10) / 10);
        end
        done10_prev = done10;
        busy10_prev = busy10;
    end

    logic done1_prev = 1'b0, busy1_prev = 1'b0;
    int   rs1 = 0;
    exp_t e1;
    always @(negedge clk) begin
        if (done1 && !done1_prev) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("table1", table1, e1.tbl);
                chk("mismatch1", mm1, e1.mm);
                chk("first_fail1", ff1, e1.ff);
                chk("pass1", pass1, e1.pass);
                chk("done_cycle1", cyc, e1.cyc);
            end
        end
        if (busy1) begin
            if (!busy1_prev) rs1 = cyc;
            chk("vector1", {a1, b1, c1, d1}, cyc - rs1);
        end
        done1_prev = done1;
        busy1_prev = busy1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push10(input logic [15:0] tbl, input int mm, input int ff,
                          input int p, input int dcyc);
        exp_t e;
        e.tbl = tbl; e.mm = mm; e.ff = ff; e.pass = p; e.cyc = dcyc;
        q10.push_back(e);
    endtask

    // Called at a negedge: start is sampled at the next posedge (E0),
    // done becomes visible at the negedge after E0 + 160.
    task automatic sweep10(input logic [15:0] ex, input logic [15:0] tbl,
                           input int mm, input int ff, input int p);
        expected10 = ex;
        start10    = 1'b1;
        push10(tbl, mm, ff, p, cyc + 1 + 160);
        @(negedge clk);
        start10 = 1'b0;
    endtask

    task automatic wait_q10(input int budget);
        int k = 0;
        while (q10.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q10.size() != 0) begin
            chk("timeout10", 1, 0);
            q10.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset10(input string tag);
        chk({tag, "_abcd"}, {a10, b10, c10, d10}, 0);
        chk({tag, "_busy"}, busy10, 0);
        chk({tag, "_done"}, done10, 0);
        chk({tag, "_pass"}, pass10, 0);
        chk({tag, "_table"}, table10, 0);
        chk({tag, "_mm"}, mm10, 0);
        chk({tag, "_ff"}, ff10, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        exp_t e;

        // Reset for two cycles, then idle with start low.
        repeat (2) @(negedge clk);
        chk_reset10("reset");
        chk("reset_busy1", busy1, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_abcd", {a10, b10, c10, d10}, 0);
            chk("idle_busy", busy10, 0);
        end

        // rst wins over start at the same edge.
        rst = 1'b1; start10 = 1'b1;
        @(negedge clk);
        chk_reset10("rst_prio");
        rst = 1'b0; start10 = 1'b0;
        @(negedge clk);

        // f = a&b, matching expected table.
        sweep10(16'hF000, 16'hF000, 0, 0, 1);
        wait_q10(400);
        repeat (3) @(negedge clk);
        chk("done_hold", done10, 1);
        chk("table_hold", table10, 16'hF000);
        chk("pass_hold", pass10, 1);

        // One mismatch at the lowest and at the highest vector.
        sweep10(16'hF001, 16'hF000, 1, 0, 0);
        wait_q10(400);
        sweep10(16'h7000, 16'hF000, 1, 15, 0);
        wait_q10(400);

        // start held high; expected changes mid-run, second sweep picks it up
        // after exactly one DONE cycle.
        expected10 = 16'hF000;
        start10    = 1'b1;
        push10(16'hF000, 0, 0, 1, cyc + 1 + 160);
        push10(16'hF000, 4, 12, 0, cyc + 1 + 321);
        repeat (40) @(negedge clk);
        expected10 = 16'h0000;
        repeat (130) @(negedge clk);
        start10 = 1'b0;
        wait_q10(400);

        // rst at E0+50 aborts the sweep; no done may follow.
        expected10 = 16'hF000;
        start10    = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset10("abort");
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_done", done10, 0);
        chk("abort_no_busy", busy10, 0);
        sweep10(16'hF000, 16'hF000, 0, 0, 1);
        wait_q10(400);

        // DWELL = 1, parity function.
        expected1 = 16'h6996;
        start1    = 1'b1;
        e.tbl = 16'h6996; e.mm = 0; e.ff = 0; e.pass = 1; e.cyc = cyc + 1 + 16;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 100 && q1.size() != 0; k++) @(negedge clk);
        if (q1.size() != 0) begin
            chk("timeout1", 1, 0);
            q1.delete();
        end
        repeat (2) @(negedge clk);
        chk("done_hold1", done1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
